// File: rtl/rv_pkg.sv
// Shared types and constants for the register-file writeback path.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Which requester owns a writeback.
    typedef enum logic {
        WB_SRC_A = 1'b0,
        WB_SRC_B = 1'b1
    } wb_src_e;

    // One writeback request as presented by a requester.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wd;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. On contention the requester that was
// not granted last time wins; the last-grant pointer moves only on a grant.
module rr_arb2
    import rv_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_req_a,
    input  logic    i_req_b,
    output logic    o_gnt_a,
    output logic    o_gnt_b,
    output wb_src_e o_src
);

    wb_src_e r_last;
    logic    w_gnt_a;
    logic    w_gnt_b;

    // Grant decode: a lone requester always wins, contention uses the pointer.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (i_req_a && i_req_b) begin
            w_gnt_a = (r_last == WB_SRC_B);
            w_gnt_b = (r_last == WB_SRC_A);
        end else begin
            w_gnt_a = i_req_a;
            w_gnt_b = i_req_b;
        end
    end

    // Last-grant pointer, starts at A.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= WB_SRC_A;
        end else if (w_gnt_a || w_gnt_b) begin
            r_last <= w_gnt_b ? WB_SRC_B : WB_SRC_A;
        end
    end

    assign o_gnt_a = w_gnt_a;
    assign o_gnt_b = w_gnt_b;
    assign o_src   = w_gnt_b ? WB_SRC_B : WB_SRC_A;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between the core (A) and MUL/DIV (B),
// with a one-cycle registered write stage and a busy scoreboard for
// outstanding MUL/DIV destinations.
// Optional macro RF_WB_BYPASS_EN: exposes the in-flight write as a bypass
// and drops the stall for a register whose busy bit clears this cycle.
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_wd,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_wd,
    output logic            b_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            hazard,
    output logic            reg_write,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] wd,
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd_val
);

    import rv_pkg::wb_req_t;
    import rv_pkg::wb_src_e;
    import rv_pkg::WB_SRC_B;
    import rv_pkg::WB_SRC_A;

    wb_req_t         w_req_a;
    wb_req_t         w_req_b;
    wb_req_t         w_sel;
    wb_src_e         w_src;
    logic            w_gnt_a;
    logic            w_gnt_b;
    logic            w_hs;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_busy_eff;

    logic            r_reg_write;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_wd;
    wb_src_e         r_src;
    logic [NREG-1:0] r_busy;

    assign w_req_a = '{valid: a_valid, rd: a_rd, wd: a_wd};
    assign w_req_b = '{valid: b_valid, rd: b_rd, wd: b_wd};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req_a (w_req_a.valid),
        .i_req_b (w_req_b.valid),
        .o_gnt_a (w_gnt_a),
        .o_gnt_b (w_gnt_b),
        .o_src   (w_src)
    );

    assign w_hs  = w_gnt_a | w_gnt_b;
    assign w_sel = (w_src == WB_SRC_B) ? w_req_b : w_req_a;

    // Write stage: capture the granted request; x0 completes but never writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_wd        <= '0;
            r_src       <= WB_SRC_A;
        end else begin
            r_reg_write <= w_hs && (w_sel.rd != '0);
            if (w_hs) begin
                r_rd  <= w_sel.rd;
                r_wd  <= w_sel.wd;
                r_src <= w_src;
            end
        end
    end

    // Scoreboard set on accepted issue, clear when a B write commits.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (iss_valid && iss_ready && (iss_rd != '0)) begin
            w_set_mask[iss_rd] = 1'b1;
        end
        if (r_reg_write && (r_src == WB_SRC_B)) begin
            w_clr_mask[r_rd] = 1'b1;
        end
    end

    // Busy bits; set and clear of different registers apply together.
    // NOTE: the scoreboard is a flop vector rather than a RAM, so it is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    assign iss_ready = ~r_busy[iss_rd];

`ifdef RF_WB_BYPASS_EN
    assign w_busy_eff = r_busy & ~w_clr_mask;
    assign fwd1_hit   = r_reg_write && (r_rd != '0) && (r_rd == rs1);
    assign fwd2_hit   = r_reg_write && (r_rd != '0) && (r_rd == rs2);
    assign fwd_val    = r_wd;
`else
    assign w_busy_eff = r_busy;
    assign fwd1_hit   = 1'b0;
    assign fwd2_hit   = 1'b0;
    assign fwd_val    = '0;
`endif

    assign hazard    = w_busy_eff[rs1] | w_busy_eff[rs2];
    assign a_ready   = w_gnt_a;
    assign b_ready   = w_gnt_b;
    assign reg_write = r_reg_write;
    assign rd        = r_rd;
    assign wd        = r_wd;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter: a vector table for arbitration and
// the write stage, then hand sequences for the scoreboard, x0 and reset.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, iss_valid;
    logic [4:0]  a_rd, b_rd, iss_rd, rs1, rs2;
    logic [31:0] a_wd, b_wd;
    logic        a_ready, b_ready, iss_ready, hazard, reg_write;
    logic [4:0]  rd;
    logic [31:0] wd, fwd_val;
    logic        fwd1_hit, fwd2_hit;

    int total = 0;
    int bad   = 0;

`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] awd;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bwd;
        logic        ea;
        logic        eb;
        logic        erw;
        logic [4:0]  erd;
        logic [31:0] ewd;
    } vec_t;

    vec_t vecs [8];

    rf_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_rd      (a_rd),
        .a_wd      (a_wd),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_rd      (b_rd),
        .b_wd      (b_wd),
        .b_ready   (b_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .hazard    (hazard),
        .reg_write (reg_write),
        .rd        (rd),
        .wd        (wd),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd_val   (fwd_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Contention starts with last grant = B (after the B-only x0 write).
        vecs[0] = '{1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd3, 32'h1234};
        vecs[1] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd3, 32'h1234};
        vecs[2] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'h55, 1'b0, 1'b1, 1'b0, 5'd0, 32'h55};
        vecs[3] = '{1'b1, 5'd4, 32'hA1,   1'b1, 5'd7, 32'hB1, 1'b1, 1'b0, 1'b1, 5'd4, 32'hA1};
        vecs[4] = '{1'b1, 5'd4, 32'hA2,   1'b1, 5'd7, 32'hB1, 1'b0, 1'b1, 1'b1, 5'd7, 32'hB1};
        vecs[5] = '{1'b1, 5'd4, 32'hA2,   1'b1, 5'd7, 32'hB2, 1'b1, 1'b0, 1'b1, 5'd4, 32'hA2};
        vecs[6] = '{1'b1, 5'd4, 32'hA3,   1'b1, 5'd7, 32'hB2, 1'b0, 1'b1, 1'b1, 5'd7, 32'hB2};
        vecs[7] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd7, 32'hB2};

        rst_n = 1'b0;
        a_valid = 1'b0; a_rd = '0; a_wd = '0;
        b_valid = 1'b0; b_rd = '0; b_wd = '0;
        iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
        #12;
        check("rst reg_write", {31'b0, reg_write}, 32'd0);
        check("rst rd", {27'b0, rd}, 32'd0);
        check("rst wd", wd, 32'd0);
        check("rst iss_ready", {31'b0, iss_ready}, 32'd1);
        check("rst hazard", {31'b0, hazard}, 32'd0);
        check("rst a_ready", {31'b0, a_ready}, 32'd0);
        check("rst b_ready", {31'b0, b_ready}, 32'd0);
        check("rst fwd", {30'b0, fwd1_hit, fwd2_hit} | fwd_val, 32'd0);
        rst_n = 1'b1;
        tick();

        // Arbitration and write stage vectors.
        for (int i = 0; i < 8; i++) begin
            a_valid = vecs[i].av; a_rd = vecs[i].ard; a_wd = vecs[i].awd;
            b_valid = vecs[i].bv; b_rd = vecs[i].brd; b_wd = vecs[i].bwd;
            #1;
            check($sformatf("v%0d a_ready", i), {31'b0, a_ready}, {31'b0, vecs[i].ea});
            check($sformatf("v%0d b_ready", i), {31'b0, b_ready}, {31'b0, vecs[i].eb});
            tick();
            check($sformatf("v%0d reg_write", i), {31'b0, reg_write}, {31'b0, vecs[i].erw});
            check($sformatf("v%0d rd", i), {27'b0, rd}, {27'b0, vecs[i].erd});
            check($sformatf("v%0d wd", i), wd, vecs[i].ewd);
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // Scoreboard: issue x10, stall WAW, x0 issue, B write clears.
        iss_valid = 1'b1; iss_rd = 5'd10; rs1 = 5'd10; rs2 = 5'd0;
        #1;
        check("sb iss_ready free", {31'b0, iss_ready}, 32'd1);
        check("sb hazard before set", {31'b0, hazard}, 32'd0);
        tick();
        check("sb hazard x10", {31'b0, hazard}, 32'd1);
        check("sb waw iss_ready", {31'b0, iss_ready}, 32'd0);
        tick();
        iss_rd = 5'd0;
        #1;
        check("sb x0 iss_ready", {31'b0, iss_ready}, 32'd1);
        tick();
        iss_valid = 1'b0; rs1 = 5'd0;
        #1;
        check("sb x0 never busy", {31'b0, hazard}, 32'd0);
        rs1 = 5'd10; rs2 = 5'd10;
        b_valid = 1'b1; b_rd = 5'd10; b_wd = 32'd42;
        #1;
        check("sb b_ready", {31'b0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        check("sb inflight reg_write", {31'b0, reg_write}, 32'd1);
        check("sb inflight rd", {27'b0, rd}, 32'd10);
        check("sb inflight wd", wd, 32'd42);
        check("sb inflight hazard", {31'b0, hazard}, BYP ? 32'd0 : 32'd1);
        check("sb fwd2_hit", {31'b0, fwd2_hit}, BYP ? 32'd1 : 32'd0);
        check("sb fwd1_hit", {31'b0, fwd1_hit}, BYP ? 32'd1 : 32'd0);
        check("sb fwd_val", fwd_val, BYP ? 32'd42 : 32'd0);
        tick();
        check("sb cleared hazard", {31'b0, hazard}, 32'd0);
        check("sb idle reg_write", {31'b0, reg_write}, 32'd0);

        // Set of x12 on the same edge that x11 clears.
        rs1 = 5'd0; rs2 = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd11;
        tick();
        iss_valid = 1'b0;
        b_valid = 1'b1; b_rd = 5'd11; b_wd = 32'd7;
        tick();
        b_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd12;
        #1;
        check("setclr iss_ready x12", {31'b0, iss_ready}, 32'd1);
        tick();
        iss_valid = 1'b0;
        rs1 = 5'd11;
        #1;
        check("setclr x11 cleared", {31'b0, hazard}, 32'd0);
        rs1 = 5'd0; rs2 = 5'd12;
        #1;
        check("setclr x12 set", {31'b0, hazard}, 32'd1);

        // Write to x0: handshake completes, no register write.
        a_valid = 1'b1; a_rd = 5'd0; a_wd = 32'hFFFF;
        #1;
        check("x0 a_ready", {31'b0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0;
        check("x0 reg_write", {31'b0, reg_write}, 32'd0);

        // Reset in the middle of a write with x5 busy.
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        iss_valid = 1'b0;
        a_valid = 1'b1; a_rd = 5'd6; a_wd = 32'h66;
        tick();
        a_valid = 1'b0; rs1 = 5'd5; rs2 = 5'd0;
        #1;
        check("mid reg_write pre", {31'b0, reg_write}, 32'd1);
        check("mid hazard pre", {31'b0, hazard}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid rst reg_write", {31'b0, reg_write}, 32'd0);
        check("mid rst hazard", {31'b0, hazard}, 32'd0);
        check("mid rst iss_ready", {31'b0, iss_ready}, 32'd1);
        check("mid rst rd", {27'b0, rd}, 32'd0);
        rst_n = 1'b1;
        rs2 = 5'd12;
        tick();
        check("post rst hazard", {31'b0, hazard}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
